// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT burst controller: FSM encoding, default widths
// and the legal FFT size range.
package fft_ctrl_pkg;

  localparam int unsigned PWIDTH_DEF = 11;
  localparam int unsigned BWIDTH_DEF = 10;
  localparam int unsigned MIN_POINT  = 8;
  localparam int unsigned MAX_POINT  = 1024;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // True when p is a power of two within [MIN_POINT, MAX_POINT].
  function automatic logic point_ok(input int unsigned p);
    return (p >= MIN_POINT) && (p <= MAX_POINT) && ((p & (p - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/fft_frame_cnt.sv
// Beat counter that wraps at point-1 and counts completed frames; flags the
// last beat of a frame and the beat that completes the whole burst.
module fft_frame_cnt
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned PWIDTH = PWIDTH_DEF,
  parameter int unsigned BWIDTH = BWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              beat,
  input  logic [PWIDTH-1:0] point,
  input  logic [BWIDTH-1:0] burst,
  output logic              last,
  output logic              frame_done
);

  localparam logic [PWIDTH-1:0] POne = PWIDTH'(1);
  localparam logic [BWIDTH-1:0] BOne = BWIDTH'(1);

  logic [PWIDTH-1:0] beat_q, beat_d;
  logic [BWIDTH-1:0] frame_q, frame_d;

  assign last = (beat_q == point - POne);
  // Asserted on the beat that closes the final frame of the burst.
  assign frame_done = beat & last & (frame_q == burst - BOne);

  // Next-state: clear on a new burst, otherwise advance on each accepted beat.
  always_comb begin
    beat_d  = beat_q;
    frame_d = frame_q;
    if (clr) begin
      beat_d  = '0;
      frame_d = '0;
    end else if (beat) begin
      if (last) begin
        beat_d  = '0;
        frame_d = frame_q + BOne;
      end else begin
        beat_d = beat_q + POne;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q  <= '0;
      frame_q <= '0;
    end else begin
      beat_q  <= beat_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: rtl/fft_burst_ctrl.sv
// Burst controller for an FFT core: latches the transform configuration on a
// start edge, gates the input/output AXI-stream handshakes per state, counts
// beats and frames on each side and generates m_axis_tlast and status flags.
module fft_burst_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned PWIDTH = PWIDTH_DEF,
  parameter int unsigned BWIDTH = BWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [PWIDTH-1:0] i_point,
  input  logic              i_inverse,
  input  logic [BWIDTH-1:0] i_burst,
  output logic [PWIDTH-1:0] o_cfg_point,
  output logic              o_cfg_inverse,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic              c_in_tvalid,
  input  logic              c_in_tready,
  input  logic              c_out_tvalid,
  output logic              c_out_tready,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_tlast_err
);

  localparam logic [BWIDTH-1:0] BOne = BWIDTH'(1);

  state_e            state_q, state_d;
  logic              start_q;
  logic              start_edge;
  logic [PWIDTH-1:0] point_q, point_d;
  logic              inverse_q, inverse_d;
  logic [BWIDTH-1:0] burst_q, burst_d;
  logic              err_q, err_d;
  logic              err_pulse_q, err_pulse_d;
  logic              cnt_clr;
  logic              in_fire, out_fire;
  logic              in_last, out_last;
  logic              in_burst_done, out_burst_done;

  assign start_edge = i_start & ~start_q;

  assign in_fire  = c_in_tvalid & c_in_tready;
  assign out_fire = m_axis_tvalid & m_axis_tready;

  fft_frame_cnt #(
    .PWIDTH(PWIDTH),
    .BWIDTH(BWIDTH)
  ) u_in_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .beat      (in_fire),
    .point     (point_q),
    .burst     (burst_q),
    .last      (in_last),
    .frame_done(in_burst_done)
  );

  fft_frame_cnt #(
    .PWIDTH(PWIDTH),
    .BWIDTH(BWIDTH)
  ) u_out_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .beat      (out_fire),
    .point     (point_q),
    .burst     (burst_q),
    .last      (out_last),
    .frame_done(out_burst_done)
  );

  // Handshake gating: input path open only in RUN, output path in RUN and DRAIN.
  always_comb begin
    s_axis_tready = 1'b0;
    c_in_tvalid   = 1'b0;
    m_axis_tvalid = 1'b0;
    c_out_tready  = 1'b0;
    if (state_q == StRun) begin
      s_axis_tready = c_in_tready;
      c_in_tvalid   = s_axis_tvalid;
    end
    if ((state_q == StRun) || (state_q == StDrain)) begin
      m_axis_tvalid = c_out_tvalid;
      c_out_tready  = m_axis_tready;
    end
  end

  assign m_axis_tlast  = m_axis_tvalid & out_last;
  assign o_cfg_point   = point_q;
  assign o_cfg_inverse = inverse_q;
  assign o_busy        = (state_q == StRun) || (state_q == StDrain);
  assign o_done        = (state_q == StDone);
  // Sticky tlast mismatch, or a one-cycle flag for a rejected FFT size.
  assign o_tlast_err   = err_q | err_pulse_q;

  // FSM next-state, configuration latch and error tracking.
  always_comb begin
    state_d     = state_q;
    point_d     = point_q;
    inverse_d   = inverse_q;
    burst_d     = burst_q;
    err_d       = err_q;
    err_pulse_d = 1'b0;
    cnt_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          if (point_ok(32'(i_point))) begin
            point_d   = i_point;
            inverse_d = i_inverse;
            burst_d   = (i_burst == '0) ? BOne : i_burst;
            err_d     = 1'b0;
            cnt_clr   = 1'b1;
            state_d   = StRun;
          end else begin
            err_pulse_d = 1'b1;
          end
        end
      end
      StRun: begin
        // Output completion is checked first so both sides finishing together ends the burst.
        if (out_burst_done) begin
          state_d = StDone;
        end else if (in_burst_done) begin
          state_d = StDrain;
        end
        if (in_fire && (s_axis_tlast != in_last)) begin
          err_d = 1'b1;
        end
      end
      StDrain: begin
        if (out_burst_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, start-edge and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      point_q     <= '0;
      inverse_q   <= 1'b0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= i_start;
      point_q     <= point_d;
      inverse_q   <= inverse_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
    end
  end

endmodule
